dmem_unit: RTL and testbench
============================

# dmem_unit

Parametrised data-memory unit for the MIPS pipeline's MEM stage, replacing the flat word-array memory. Takes byte addresses with byte/halfword/word access sizes, sign- or zero-extends loads, flags misaligned and out-of-range accesses, and models a configurable access latency through a busy/done handshake that the hazard unit uses to stall the pipeline.

## Interface
- `DEPTH`, 1024: number of 32-bit words. Power of two, ≥ 4.
- `LATENCY`, 1: cycles from accept to completion edge. Range 1..8.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 1: access request, sampled only when `busy`=0.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `unsignedLd` in 1: loads zero-extend when 1, sign-extend when 0.
- `address` in 32: byte address.
- `writeData` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `busy` out 1: access in flight, stall request to pipeline.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; access was rejected.
- `readData` out 32: load result, held until next load completes.

## Operation
- Little-endian: byte lane k = `address[1:0]` occupies bits [8k+7:8k]. Word index = `address[31:2]`.
- States: IDLE, ACTIVE. Counter width 3 bits.
- IDLE: on edge with `req`=1, latch `we`, `size`, `unsignedLd`, `address`, `writeData`, load counter with `LATENCY`-1, go ACTIVE, `busy`←1.
- ACTIVE: counter decrements each edge; on the edge where counter = 0 (completion edge), perform the access, `done`←1, `busy`←0, go IDLE.
- Fault on completion if any: `size`=11; half with `address[0]`=1; word with `address[1:0]`≠00; word index ≥ `DEPTH`. Faulted store writes nothing; faulted load sets `readData`←0. `fault` pulses with `done` only.
- Store: byte writes the single addressed lane, half writes lanes {1,0} or {3,2}, word writes all four; other lanes unchanged.
- Load: select lane(s), extend to 32 bits per `unsignedLd` (ignored for word), register into `readData`.
- Store completion leaves `readData` unchanged.
- `req` while `busy`=1 is ignored, not queued; requester holds `req` and operands until accepted.
- Load completing after a store to the same word returns post-store data, since the store commits on its own completion edge.

## Timing
- Reset values: `busy`=0, `done`=0, `fault`=0, `readData`=0, state IDLE, counter 0.
- Accept at edge T0 → `busy` high for cycles T0..T0+`LATENCY`-1 → completion edge T0+`LATENCY` → `done`/`fault`/`readData` valid in the following cycle.
- `done` is high exactly one cycle, while `busy` is already 0. A new `req` in the `done` cycle is accepted at the next edge, giving a minimum issue interval of `LATENCY`+1 cycles.
- `rst` mid-access aborts it: no memory write, no `done` pulse, outputs return to reset values on that edge.
- `rst` and `req` on the same edge: reset wins, request is dropped.
- The memory array is never read combinationally; all outputs are registered.

## Configuration
- `DMEM_CLEAR_ON_RESET_EN` defined: `rst` additionally zeroes all `DEPTH` words on the reset edge.
- Not defined: `rst` resets control state and outputs only; array contents persist across reset, and after power-up are X until written.

## Test plan
- `LATENCY`=1: store word 0xDEADBEEF at 0x10, then load word 0x10 → `busy` high 1 cycle per access, `done` one cycle after each completion edge, `readData`=0xDEADBEEF, `fault`=0.
- `LATENCY`=3: store byte 0x80 at 0x21, then load byte 0x21 signed → 0xFFFFFF80. Same load unsigned → 0x00000080. Load word 0x20 shows only lane 1 changed.
- Load half at 0x13 → `fault`=1 with `done`, `readData`=0x00000000. Store word at 0x22 → `fault`=1 and the word at 0x20 is unchanged.
- `DEPTH`=1024: load word at 0x1000 (index 1024) → `fault`=1. `size`=11 at 0x0 → `fault`=1.
- Assert `req` continuously with changing `address` while `busy` → only the operands present at the accept edge are used; the second access is accepted exactly `LATENCY`+1 cycles after the first.
- Assert `rst` one cycle after accepting a store of 0x12345678 (`LATENCY`=3) → no `done`, memory word unchanged (0 if `DMEM_CLEAR_ON_RESET_EN` is defined), all outputs 0 on the next cycle.

Source files
------------

// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressable data memory for the MEM stage.
// Byte/half/word loads and stores, sign/zero extension, misalignment and
// range faults, and a fixed access latency exposed through busy/done.
// Optional build macro: DMEM_CLEAR_ON_RESET_EN zeroes the array on rst.
module dmem_unit #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsignedLd,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] readData
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  cnt_r, cnt_nxt_s;
  logic        accept_s, complete_s;

  logic        we_r, uns_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r;

  logic [31:0] mem_r [DEPTH];

  logic          fault_s, wr_en_s;
  logic [3:0]    be_s;
  logic [31:0]   wlane_s, word_s, shifted_s, ld_s;
  logic [AW-1:0] idx_s;

  // Rejects illegal size, misaligned half/word and word index beyond DEPTH.
  function automatic logic access_fault(input logic [1:0] sz, input logic [31:0] a);
    logic f;
    f = 1'b0;
    case (sz)
      2'b00:   f = 1'b0;
      2'b01:   f = a[0];
      2'b10:   f = (a[1:0] != 2'b00);
      default: f = 1'b1;
    endcase
    if ({2'b00, a[31:2]} >= 32'(DEPTH)) begin
      f = 1'b1;
    end else begin
      f = f;
    end
    return f;
  endfunction

  // Extends a right-aligned byte or half to 32 bits; words pass unchanged.
  function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic u,
                                              input logic [31:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    case (sz)
      2'b00:   r = u ? {24'h00_0000, v[7:0]} : {{24{v[7]}}, v[7:0]};
      2'b01:   r = u ? {16'h0000, v[15:0]}   : {{16{v[15]}}, v[15:0]};
      2'b10:   r = v;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // State and latency counter register; reset wins over a same-edge request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: accept in IDLE, count down in ACTIVE, complete at zero.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          accept_s    = 1'b1;
          state_nxt_s = ACTIVE;
          cnt_nxt_s   = CNT_INIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (cnt_r == 3'd0) begin
          complete_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // Operand capture at the accept edge; later changes on the inputs are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      size_r  <= 2'b00;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      we_r    <= we;
      uns_r   <= unsignedLd;
      size_r  <= size;
      addr_r  <= address;
      wdata_r <= writeData;
    end
  end

  assign fault_s = access_fault(size_r, addr_r);
  assign idx_s   = addr_r[AW+1:2];
  assign wr_en_s = complete_s & we_r & ~fault_s & ~rst;

  // Store lane enables and lane-replicated write data.
  always_comb begin
    be_s    = 4'b0000;
    wlane_s = wdata_r;
    case (size_r)
      2'b00: begin
        be_s    = 4'b0001 << addr_r[1:0];
        wlane_s = {4{wdata_r[7:0]}};
      end
      2'b01: begin
        be_s    = addr_r[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{wdata_r[15:0]}};
      end
      2'b10:   be_s = 4'b1111;
      default: be_s = 4'b0000;
    endcase
  end

  // Load path: select the addressed lane(s) and extend; consumed only by a register.
  always_comb begin
    word_s    = mem_r[idx_s];
    shifted_s = word_s >> {addr_r[1:0], 3'b000};
    ld_s      = load_extend(size_r, uns_r, shifted_s);
  end

  // Memory array: lane writes on a non-faulting store completion.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
`endif
    end else if (wr_en_s) begin
      for (int k = 0; k < 4; k++) begin
        if (be_s[k]) begin
          mem_r[idx_s][8*k +: 8] <= wlane_s[8*k +: 8];
        end
      end
    end
  end

  // Registered handshake and load result; stores leave readData untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      readData <= 32'h0000_0000;
    end else begin
      busy  <= (state_nxt_s == ACTIVE);
      done  <= complete_s;
      fault <= complete_s & fault_s;
      if (complete_s && !we_r) begin
        readData <= fault_s ? 32'h0000_0000 : ld_s;
      end
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: instance 0 with LATENCY=1, instance 1 with LATENCY=3.
module tb_dmem_unit;

  typedef struct packed {
    logic        f;
    logic [31:0] rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a [2];
  logic        req_a [2];
  logic        we_a  [2];
  logic        uns_a [2];
  logic [1:0]  size_a[2];
  logic [31:0] addr_a[2];
  logic [31:0] wd_a  [2];
  logic        busy_a[2];
  logic        done_a[2];
  logic        fault_a[2];
  logic [31:0] rd_a  [2];

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] last_rd[2];
  int          n_cmp = 0;
  int          n_err = 0;

  exp_t m_e;
  bit   m_got;

  dmem_unit #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst_a[0]), .req(req_a[0]), .we(we_a[0]), .size(size_a[0]),
    .unsignedLd(uns_a[0]), .address(addr_a[0]), .writeData(wd_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .fault(fault_a[0]), .readData(rd_a[0]));

  dmem_unit #(.DEPTH(1024), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst_a[1]), .req(req_a[1]), .we(we_a[1]), .size(size_a[1]),
    .unsignedLd(uns_a[1]), .address(addr_a[1]), .writeData(wd_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .fault(fault_a[1]), .readData(rd_a[1]));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic push(input int k, input logic f, input logic [31:0] rd);
    exp_t e;
    e.f  = f;
    e.rd = rd;
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Monitor: every done pulse pops one expectation and compares fault/readData.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_a[i] === 1'b1) begin
        m_got = 1'b0;
        if (i == 0 && sb0.size() > 0) begin m_e = sb0.pop_front(); m_got = 1'b1; end
        if (i == 1 && sb1.size() > 0) begin m_e = sb1.pop_front(); m_got = 1'b1; end
        n_cmp++;
        if (!m_got) begin
          n_err++;
          $display("FAIL unexpected_done dut%0d: fault=%b readData=%h with nothing pending",
                   i, fault_a[i], rd_a[i]);
        end else if (fault_a[i] !== m_e.f || rd_a[i] !== m_e.rd || busy_a[i] !== 1'b0) begin
          n_err++;
          $display("FAIL response dut%0d: got fault=%b readData=%h busy=%b, required fault=%b readData=%h busy=0",
                   i, fault_a[i], rd_a[i], busy_a[i], m_e.f, m_e.rd);
        end
      end
    end
  end

  // One complete access: drive, accept, count busy cycles, wait for done.
  task automatic op(input int k, input logic w, input logic [1:0] sz, input logic u,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic ef, input logic [31:0] er);
    int cyc;
    if (w) begin
      push(k, ef, last_rd[k]);
    end else begin
      push(k, ef, er);
      last_rd[k] = er;
    end
    @(negedge clk);
    we_a[k] = w; size_a[k] = sz; uns_a[k] = u; addr_a[k] = a; wd_a[k] = d;
    req_a[k] = 1'b1;
    @(posedge clk); #1;
    req_a[k] = 1'b0; addr_a[k] = 32'hFFFF_FFFC; wd_a[k] = 32'h0000_0000; size_a[k] = 2'b11;
    cyc = 0;
    while (busy_a[k] === 1'b1 && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("busy_cycles dut%0d addr %h", k, a), 32'(cyc), (k == 0) ? 32'd1 : 32'd3);
    check($sformatf("done_pulse dut%0d addr %h", k, a), {31'd0, done_a[k]}, 32'd1);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  cyc;
    bit  seen_done;
    bit  any_out;
    logic [31:0] exp_after_rst;
    for (int k = 0; k < 2; k++) begin
      rst_a[k] = 1'b1; req_a[k] = 1'b0; we_a[k] = 1'b0; uns_a[k] = 1'b0;
      size_a[k] = 2'b10; addr_a[k] = 32'h0; wd_a[k] = 32'h0; last_rd[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_outputs dut%0d", k),
            {29'd0, busy_a[k], done_a[k], fault_a[k]}, 32'd0);
      check($sformatf("reset_readData dut%0d", k), rd_a[k], 32'h0);
    end

    // LATENCY=1 store/load word.
    op(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF);

    // LATENCY=3 lane behaviour.
    op(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 1'b0, 32'h0);
    op(1, 1'b1, 2'b00, 1'b0, 32'h21, 32'hABCD_EF80, 1'b0, 32'h0);
    op(1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0, 32'hFFFF_FF80);
    op(1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0, 32'h0000_0080);
    op(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1122_8044);
    op(1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0, 32'hFFFF_8044);
    op(1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0000_8044);
    op(1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, 32'h0000_1122);
    // Faults.
    op(1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
    op(1, 1'b1, 2'b10, 1'b0, 32'h22, 32'h9999_9999, 1'b1, 32'h0);
    op(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1122_8044);
    // Store keeps readData; byte in lane 3.
    op(1, 1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_005A, 1'b0, 32'h0);
    op(1, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b0, 32'h0000_005A);
    op(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h5A22_8044);
    op(1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);
    op(1, 1'b0, 2'b11, 1'b0, 32'h0,    32'h0, 1'b1, 32'h0);
    op(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, 1'b0, 32'h0);

    // req held high with operands changing while busy.
    push(1, 1'b0, 32'hCAFE_F00D);
    push(1, 1'b0, 32'h5A22_8044);
    last_rd[1] = 32'h5A22_8044;
    @(negedge clk);
    we_a[1] = 1'b0; size_a[1] = 2'b10; uns_a[1] = 1'b0; addr_a[1] = 32'h10; req_a[1] = 1'b1;
    @(posedge clk); #1;
    size_a[1] = 2'b01; addr_a[1] = 32'h13;
    cyc = 0; seen_done = 1'b0;
    while (cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
      if (busy_a[1] === 1'b1 && seen_done) break;
      if (done_a[1] === 1'b1) begin
        seen_done = 1'b1; size_a[1] = 2'b10; addr_a[1] = 32'h20;
      end else begin
        addr_a[1] = addr_a[1] + 32'h4;
      end
    end
    check("reissue_interval", 32'(cyc), 32'd4);
    req_a[1] = 1'b0;
    cyc = 0;
    while (busy_a[1] === 1'b1 && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("second_busy_cycles", 32'(cyc), 32'd3);
    @(negedge clk);

    // Reset one cycle after accepting a store aborts it.
    @(negedge clk);
    we_a[1] = 1'b1; size_a[1] = 2'b10; addr_a[1] = 32'h20; wd_a[1] = 32'h1234_5678; req_a[1] = 1'b1;
    @(posedge clk); #1;
    req_a[1] = 1'b0;
    @(negedge clk);
    rst_a[1] = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs", {29'd0, busy_a[1], done_a[1], fault_a[1]}, 32'd0);
    check("abort_readData", rd_a[1], 32'h0);
    @(negedge clk);
    rst_a[1] = 1'b0;
    any_out = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done_a[1] !== 1'b0 || busy_a[1] !== 1'b0) any_out = 1'b1;
    end
    check("no_done_after_abort", {31'd0, any_out}, 32'd0);
    last_rd[1] = 32'h0;
`ifdef DMEM_CLEAR_ON_RESET_EN
    exp_after_rst = 32'h0;
`else
    exp_after_rst = 32'h5A22_8044;
`endif
    op(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, exp_after_rst);

    repeat (3) @(negedge clk);
    check("scoreboard0_drained", 32'(sb0.size()), 32'd0);
    check("scoreboard1_drained", 32'(sb1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
